// File: rtl/ps2_mouse_tracker_pkg.sv
// Shared types for the PS/2 mouse tracker: FSM state enums, packet header layout
// and the 11-bit screen-coordinate type shared with the physics step.
package ps2_mouse_tracker_pkg;

    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_DATA,
        BIT_PARITY,
        BIT_STOP
    } bit_state_t;

    typedef enum logic [1:0] {
        PKT_B0,
        PKT_B1,
        PKT_B2
    } pkt_state_t;

    // Bit positions inside the first (header) byte of a mouse packet.
    localparam int B0_LEFT  = 0;
    localparam int B0_SYNC  = 3;
    localparam int B0_XSIGN = 4;
    localparam int B0_YSIGN = 5;
    localparam int B0_XOVF  = 6;
    localparam int B0_YOVF  = 7;

    typedef logic [10:0] coord_t;

    typedef struct packed {
        logic yovf;
        logic xovf;
        logic ysign;
        logic xsign;
        logic left;
    } hdr_t;

    function automatic coord_t clamp_coord(input logic signed [12:0] v,
                                           input logic signed [12:0] hi);
        coord_t r;
        if (v < 13'sd0)
            r = '0;
        else if (v > hi)
            r = hi[10:0];
        else
            r = v[10:0];
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame FSM and
// idle timeout. Parity is checked only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx_frame
    import ps2_mouse_tracker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic          bit_in;
    bit_state_t    state_q, state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [TW-1:0] tmo_cnt;
    logic          parity_ok;
    logic          stop_edge;

    // Pins idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[1];
    assign bit_in  = data_sync[1];
    assign timeout = !fall && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= BIT_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BIT_IDLE:   if (fall && !bit_in)          state_d = BIT_DATA;
            BIT_DATA:   if (fall && bit_cnt == 3'd7)  state_d = BIT_PARITY;
            BIT_PARITY: if (fall)                     state_d = BIT_STOP;
            BIT_STOP:   if (fall)                     state_d = BIT_IDLE;
            default:                                  state_d = BIT_IDLE;
        endcase
        if (timeout)
            state_d = BIT_IDLE;
    end

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            par_bit <= 1'b0;
        else if (fall && state_q == BIT_PARITY)
            par_bit <= bit_in;
    end

    // Odd parity over the data byte plus the parity bit.
    assign parity_ok = ^{shift, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            shift   <= '0;
            tmo_cnt <= '0;
        end else begin
            // Counter saturates so an idle line yields one timeout pulse only.
            if (fall)
                tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (fall) begin
                case (state_q)
                    BIT_IDLE: bit_cnt <= '0;
                    BIT_DATA: begin
                        shift   <= {bit_in, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign stop_edge  = fall && (state_q == BIT_STOP);
    assign byte_valid = stop_edge && bit_in && parity_ok;
    assign frame_err  = stop_edge && !(bit_in && parity_ok);
    assign byte_data  = shift;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker top: 3-byte packet assembly, clamped cursor accumulation and
// left-click edge detection. Optional parity checking via PS2_PARITY_CHECK_EN.
module ps2_mouse_tracker
    import ps2_mouse_tracker_pkg::*;
#(
    parameter int RES_X          = 1280,
    parameter int RES_Y          = 800,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   ps2_clk,
    input  logic   ps2_data,
    output coord_t mouse_x,
    output coord_t mouse_y,
    output logic   mouse_click,
    output logic   packet_valid,
    output logic   frame_err
);

    localparam coord_t CENTER_X = coord_t'(RES_X / 2);
    localparam coord_t CENTER_Y = coord_t'(RES_Y / 2);
    localparam logic signed [12:0] MAX_X = 13'(RES_X - 1);
    localparam logic signed [12:0] MAX_Y = 13'(RES_Y - 1);

    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              rx_err;
    logic              rx_timeout;
    pkt_state_t        pkt_q, pkt_d;
    logic              packet_done;
    hdr_t              hdr;
    logic [7:0]        b1;
    logic              prev_left;
    logic signed [12:0] dx, dy, x_sum, y_sum;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(rx_valid),
        .byte_data (rx_byte),
        .frame_err (rx_err),
        .timeout   (rx_timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pkt_q <= PKT_B0;
        else
            pkt_q <= pkt_d;
    end

    // A header without the always-one sync bit is dropped so the stream resyncs.
    always_comb begin
        pkt_d       = pkt_q;
        packet_done = 1'b0;
        if (rx_valid) begin
            case (pkt_q)
                PKT_B0: if (rx_byte[B0_SYNC]) pkt_d = PKT_B1;
                PKT_B1: pkt_d = PKT_B2;
                PKT_B2: begin
                    pkt_d       = PKT_B0;
                    packet_done = 1'b1;
                end
                default: pkt_d = PKT_B0;
            endcase
        end
        if (rx_err || rx_timeout)
            pkt_d = PKT_B0;
    end

    // PS/2 +Y points up while screen y grows downward, hence the subtraction.
    always_comb begin
        dx    = hdr.xovf ? 13'sd0 : {{4{hdr.xsign}}, hdr.xsign, b1};
        dy    = hdr.yovf ? 13'sd0 : {{4{hdr.ysign}}, hdr.ysign, rx_byte};
        x_sum = $signed({2'b00, mouse_x}) + dx;
        y_sum = $signed({2'b00, mouse_y}) - dy;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mouse_x      <= CENTER_X;
            mouse_y      <= CENTER_Y;
            mouse_click  <= 1'b0;
            packet_valid <= 1'b0;
            frame_err    <= 1'b0;
            prev_left    <= 1'b0;
            hdr          <= '0;
            b1           <= '0;
        end else begin
            mouse_click  <= 1'b0;
            packet_valid <= 1'b0;
            frame_err    <= rx_err;
            if (rx_valid && pkt_q == PKT_B0 && rx_byte[B0_SYNC]) begin
                hdr.left  <= rx_byte[B0_LEFT];
                hdr.xsign <= rx_byte[B0_XSIGN];
                hdr.ysign <= rx_byte[B0_YSIGN];
                hdr.xovf  <= rx_byte[B0_XOVF];
                hdr.yovf  <= rx_byte[B0_YOVF];
            end
            if (rx_valid && pkt_q == PKT_B1)
                b1 <= rx_byte;
            if (packet_done) begin
                mouse_x      <= clamp_coord(x_sum, MAX_X);
                mouse_y      <= clamp_coord(y_sum, MAX_Y);
                packet_valid <= 1'b1;
                mouse_click  <= hdr.left && !prev_left;
                prev_left    <= hdr.left;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: bit-banged PS/2 packets with hand-computed
// cursor, pulse and error expectations.
module tb_ps2_mouse_tracker;

    localparam int TMO = 200;

    logic        clk;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] mouse_x;
    logic [10:0] mouse_y;
    logic        mouse_click;
    logic        packet_valid;
    logic        frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int pv_cnt   = 0;
    int clk_cnt  = 0;
    int err_cnt  = 0;
    int pv0, ck0, er0;

    ps2_mouse_tracker #(
        .RES_X         (1280),
        .RES_Y         (800),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .mouse_x     (mouse_x),
        .mouse_y     (mouse_y),
        .mouse_click (mouse_click),
        .packet_valid(packet_valid),
        .frame_err   (frame_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            if (packet_valid) pv_cnt++;
            if (mouse_click)  clk_cnt++;
            if (frame_err)    err_cnt++;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // drivers
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(stop);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b1, 1'b0);
        send_byte(b1, 1'b1, 1'b0);
        send_byte(b2, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
    endtask

    task automatic snap();
        pv0 = pv_cnt;
        ck0 = clk_cnt;
        er0 = err_cnt;
    endtask

    initial begin
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        do_reset();

        check_eq("reset_x", int'(mouse_x), 640);
        check_eq("reset_y", int'(mouse_y), 400);
        check_eq("reset_click", int'(mouse_click), 0);
        check_eq("reset_pv", int'(packet_valid), 0);
        check_eq("reset_ferr", int'(frame_err), 0);

        // basic motion
        snap();
        send_packet(8'h08, 8'h0A, 8'h05);
        check_eq("move_x", int'(mouse_x), 650);
        check_eq("move_y", int'(mouse_y), 395);
        check_eq("move_pv", pv_cnt - pv0, 1);
        check_eq("move_click", clk_cnt - ck0, 0);

        // click edge, then held button
        snap();
        send_packet(8'h09, 8'h00, 8'h00);
        check_eq("click_first", clk_cnt - ck0, 1);
        check_eq("click_pv", pv_cnt - pv0, 1);
        check_eq("click_x_hold", int'(mouse_x), 650);
        snap();
        send_packet(8'h09, 8'h00, 8'h00);
        check_eq("click_held", clk_cnt - ck0, 0);

        // clamping
        do_reset();
        send_packet(8'h18, 8'h00, 8'h00);
        check_eq("clamp_x_step1", int'(mouse_x), 384);
        send_packet(8'h18, 8'h00, 8'h00);
        send_packet(8'h18, 8'h00, 8'h00);
        check_eq("clamp_x_low", int'(mouse_x), 0);
        send_packet(8'h28, 8'h00, 8'h00);
        check_eq("clamp_y_step1", int'(mouse_y), 656);
        send_packet(8'h28, 8'h00, 8'h00);
        check_eq("clamp_y_high", int'(mouse_y), 799);
        check_eq("clamp_x_kept", int'(mouse_x), 0);

        // X overflow
        do_reset();
        snap();
        send_packet(8'h48, 8'hFF, 8'h00);
        check_eq("ovf_x", int'(mouse_x), 640);
        check_eq("ovf_y", int'(mouse_y), 400);
        check_eq("ovf_pv", pv_cnt - pv0, 1);

        // bad stop bit restarts the packet
        snap();
        send_byte(8'h08, 1'b1, 1'b0);
        send_byte(8'h0A, 1'b0, 1'b0);
        check_eq("stop_ferr", err_cnt - er0, 1);
        send_packet(8'h08, 8'h02, 8'h03);
        check_eq("stop_resync_x", int'(mouse_x), 642);
        check_eq("stop_resync_y", int'(mouse_y), 397);
        check_eq("stop_resync_pv", pv_cnt - pv0, 1);

        // bad parity
        snap();
        send_byte(8'h08, 1'b1, 1'b1);
        send_byte(8'h04, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
        check_eq("par_ferr", err_cnt - er0, 1);
        check_eq("par_pv", pv_cnt - pv0, 0);
        check_eq("par_x", int'(mouse_x), 642);
`else
        check_eq("par_ferr", err_cnt - er0, 0);
        check_eq("par_pv", pv_cnt - pv0, 1);
        check_eq("par_x", int'(mouse_x), 646);
`endif

        // timeout discards a partial packet
        do_reset();
        snap();
        send_byte(8'h08, 1'b1, 1'b0);
        send_byte(8'h05, 1'b1, 1'b0);
        repeat (TMO + 10) @(negedge clk);
        send_packet(8'h08, 8'h01, 8'h01);
        check_eq("tmo_x", int'(mouse_x), 641);
        check_eq("tmo_y", int'(mouse_y), 399);
        check_eq("tmo_pv", pv_cnt - pv0, 1);
        check_eq("tmo_ferr", err_cnt - er0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
